// File: rtl/seg_scan_pkg.sv
// Shared widths, idle levels and the digit-slice helper for the 7-segment scanner.
package seg_scan_pkg;

  localparam int         NDIG    = 4;
  localparam int         SEG_W   = 7;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  typedef logic [NDIG*SEG_W-1:0] seg_bus_t;
  typedef logic [SEG_W-1:0]      seg_t;
  typedef logic [1:0]            dig_t;

  // Digit k occupies bits [7k+6:7k] of the packed encoder bus.
  function automatic seg_t digit_slice(input seg_bus_t bus, input dig_t k);
    return bus[int'(k)*SEG_W +: SEG_W];
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Encoder-side inputs and display-pin outputs of the scanner, bundled as one port.
interface seg_scan_if;
  import seg_scan_pkg::*;

  logic                   en;
  logic [NDIG*SEG_W-1:0]  seg_in;
  logic [NDIG-1:0]        dp_in;
  logic [3:0]             bright;
  logic [SEG_W-1:0]       seg_out;
  logic                   dp_out;
  logic [NDIG-1:0]        an;
  logic                   frame;

  modport master (
    output en, seg_in, dp_in, bright,
    input  seg_out, dp_out, an, frame
  );

  modport slave (
    input  en, seg_in, dp_in, bright,
    output seg_out, dp_out, an, frame
  );
endinterface

// File: rtl/seg_scan_timer.sv
// Slot/digit counters for the scanner; parks at the last slot position while disabled
// so the first enabled edge always starts a fresh frame.
module seg_scan_timer
  import seg_scan_pkg::*;
#(
  parameter int CLK_DIV = 12500,
  parameter int CNT_W   = $clog2(CLK_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output dig_t             o_dig,
  output logic             o_run,
  output logic             o_load,
  output logic             o_frame
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  dig_t             r_dig;
  logic             r_run;
  logic             r_frame;
  logic             w_wrap;

  assign w_wrap  = (r_cnt == CNT_MAX);
  // Entering (dig=0, cnt=0) is only possible from the parked/last position.
  assign o_load  = i_en && w_wrap && (r_dig == dig_t'(NDIG - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= CNT_MAX;
      r_dig   <= dig_t'(NDIG - 1);
      r_run   <= 1'b0;
      r_frame <= 1'b0;
    end else if (!i_en) begin
      r_cnt   <= CNT_MAX;
      r_dig   <= dig_t'(NDIG - 1);
      r_run   <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_run   <= 1'b1;
      r_frame <= o_load;
      if (w_wrap) begin
        r_cnt <= '0;
        r_dig <= r_dig + dig_t'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_cnt   = r_cnt;
  assign o_dig   = r_dig;
  assign o_run   = r_run;
  assign o_frame = r_frame;

endmodule

// File: rtl/seg_scan.sv
// Multiplexed common-anode 7-segment scanner: frame-coherent shadow of the encoder bus,
// per-slot blanking, and a 16-step brightness PWM within the lit phase.
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int CLK_DIV = 12500,
  parameter int BLANK   = 64
) (
  input  logic    clk,
  input  logic    rst,
  seg_scan_if.slave bus
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] w_cnt;
  dig_t             w_dig;
  logic             w_run;
  logic             w_load;
  logic             w_frame;
  logic             w_on;
  logic [3:0]       w_p;
  logic             w_lit;
  logic [NDIG-1:0]  w_an_lit;

  seg_bus_t         r_seg;
  logic [NDIG-1:0]  r_dp;
  logic [NDIG-1:0]  r_an;
  seg_t             r_seg_out;
  logic             r_dp_out;

  seg_scan_timer #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_en    (bus.en),
    .o_cnt   (w_cnt),
    .o_dig   (w_dig),
    .o_run   (w_run),
    .o_load  (w_load),
    .o_frame (w_frame)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= '1;
      r_dp  <= '1;
    end else if (w_load) begin
      r_seg <= bus.seg_in;
      r_dp  <= bus.dp_in;
    end
  end

  assign w_on  = (w_cnt >= CNT_W'(BLANK));
  assign w_p   = 4'(w_cnt - CNT_W'(BLANK));
  // w_run keeps the parked position from flashing digit 3 on the first enabled edge.
  assign w_lit = bus.en && w_run && w_on && (w_p <= bus.bright);

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_an
      assign w_an_lit[gi] = (w_dig != dig_t'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an      <= AN_OFF;
      r_seg_out <= SEG_OFF;
      r_dp_out  <= 1'b1;
    end else if (w_lit) begin
      r_an      <= w_an_lit;
      r_seg_out <= digit_slice(r_seg, w_dig);
      r_dp_out  <= r_dp[w_dig];
    end else begin
      r_an      <= AN_OFF;
      r_seg_out <= SEG_OFF;
      r_dp_out  <= 1'b1;
    end
  end

  assign bus.an      = r_an;
  assign bus.seg_out = r_seg_out;
  assign bus.dp_out  = r_dp_out;
  assign bus.frame   = w_frame;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: a frame-position model predicts every output cycle,
// a monitor pops and compares after each rising edge.
module tb_seg_scan;

  localparam int CLK_DIV = 40;
  localparam int BLANK   = 4;
  localparam int FRAME   = 4 * CLK_DIV;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   cyc;

  exp_t exp_q[$];
  int   frame_cyc[$];

  bit   win_en;
  int   win_cnt;
  int   lit_cnt;

  // reference model: position within the frame, counted from the load edge
  bit          m_running;
  int          m_pos;
  logic [27:0] m_seg;
  logic [3:0]  m_dp;

  seg_scan_if bus ();

  seg_scan #(.CLK_DIV(CLK_DIV), .BLANK(BLANK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic en, input logic [27:0] seg, input logic [3:0] dp,
                      input logic [3:0] br);
    exp_t e;
    int   d;
    int   c;
    @(negedge clk);
    bus.en     = en;
    bus.seg_in = seg;
    bus.dp_in  = dp;
    bus.bright = br;
    e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.frame = 1'b0;
    if (!en) begin
      m_running = 0;
    end else if (!m_running) begin
      m_running = 1;
      m_pos     = 0;
      m_seg     = seg;
      m_dp      = dp;
      e.frame   = 1'b1;
    end else begin
      d = m_pos / CLK_DIV;
      c = m_pos % CLK_DIV;
      if (c >= BLANK && ((c - BLANK) % 16) <= int'(br)) begin
        e.an    = 4'hF;
        e.an[d] = 1'b0;
        e.seg   = m_seg[d*7 +: 7];
        e.dp    = m_dp[d];
      end
      m_pos = m_pos + 1;
      if (m_pos == FRAME) begin
        m_pos   = 0;
        m_seg   = seg;
        m_dp    = dp;
        e.frame = 1'b1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic check_blank(input string name);
    checks++;
    if (bus.an !== 4'hF || bus.seg_out !== 7'h7F || bus.dp_out !== 1'b1 || bus.frame !== 1'b0) begin
      errors++;
      $display("FAIL %s: got an=%h seg=%h dp=%b frame=%b, want an=f seg=7f dp=1 frame=0",
               name, bus.an, bus.seg_out, bus.dp_out, bus.frame);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // monitor: one expected entry per rising edge while out of reset
  initial begin
    exp_t e;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.frame === 1'b1) frame_cyc.push_back(cyc);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.an !== e.an || bus.seg_out !== e.seg || bus.dp_out !== e.dp || bus.frame !== e.frame) begin
          errors++;
          $display("FAIL out cyc=%0d: got an=%h seg=%h dp=%b frame=%b, want an=%h seg=%h dp=%b frame=%b",
                   cyc, bus.an, bus.seg_out, bus.dp_out, bus.frame, e.an, e.seg, e.dp, e.frame);
        end
        if (e.frame) $display("frame cyc=%0d shadow seg=%h dp=%h", cyc, m_seg, m_dp);
        if (win_en && win_cnt < FRAME) begin
          win_cnt++;
          if (bus.an !== 4'hF) lit_cnt++;
        end
      end
    end
  end

  task automatic run(input int n, input logic [27:0] seg, input logic [3:0] dp, input logic [3:0] br);
    for (int i = 0; i < n; i++) step(1'b1, seg, dp, br);
  endtask

  task automatic run_to(input int pos, input logic [27:0] seg, input logic [3:0] dp, input logic [3:0] br);
    for (int i = 0; i < 2 * FRAME && !(m_running && m_pos == pos); i++) step(1'b1, seg, dp, br);
  endtask

  task automatic lit_window(input logic [27:0] seg, input logic [3:0] br, input int want, input string name);
    run(10, seg, 4'h0, br);
    win_cnt = 0;
    lit_cnt = 0;
    win_en  = 1;
    run(FRAME + 4, seg, 4'h0, br);
    win_en  = 0;
    check_int(name, lit_cnt, want);
  endtask

  localparam logic [27:0] SEG_A = {7'h78, 7'h30, 7'h24, 7'h79};
  localparam logic [27:0] SEG_B = {7'h12, 7'h02, 7'h40, 7'h19};
  localparam logic [27:0] SEG_C = {7'h00, 7'h10, 7'h08, 7'h03};

  initial begin
    logic [27:0] r_seg;
    logic [3:0]  r_dp;
    logic [3:0]  r_br;
    errors = 0; checks = 0;
    win_en = 0; win_cnt = 0; lit_cnt = 0;
    m_running = 0; m_pos = 0; m_seg = '1; m_dp = '1;
    rst = 1'b1;
    bus.en = 1'b0; bus.seg_in = SEG_A; bus.dp_in = 4'hE; bus.bright = 4'hF;
    #1;
    check_blank("reset_state");
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b0;

    // basic scan order, frame spacing
    frame_cyc.delete();
    run(2 * FRAME + 10, SEG_A, 4'hE, 4'hF);
    check_int("frame_count", frame_cyc.size(), 3);
    if (frame_cyc.size() >= 2)
      check_int("frame_spacing", frame_cyc[1] - frame_cyc[0], FRAME);

    // mid-frame seg_in change stays hidden until the next load
    run_to(CLK_DIV + 10, SEG_A, 4'hE, 4'hF);
    run(2 * FRAME, SEG_B, 4'h5, 4'hF);

    // brightness duty
    lit_window(SEG_B, 4'h0, 12, "lit_bright0");
    lit_window(SEG_B, 4'h7, 80, "lit_bright7");
    lit_window(SEG_B, 4'hF, 144, "lit_bright15");

    // en drop in digit 2 ON phase, restart with fresh data
    run_to(2 * CLK_DIV + 12, SEG_B, 4'h5, 4'hF);
    for (int i = 0; i < 5; i++) step(1'b0, SEG_B, 4'h5, 4'hF);
    run(FRAME + 20, SEG_C, 4'hA, 4'hF);

    // seg_in present only on the load edge
    run_to(FRAME - 1, SEG_C, 4'hA, 4'hF);
    step(1'b1, SEG_A, 4'h3, 4'hF);
    run(FRAME + 5, SEG_C, 4'hA, 4'hF);

    // asynchronous reset while lit
    run_to(CLK_DIV + 20, SEG_C, 4'hA, 4'hF);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_blank("async_reset");
    exp_q.delete();
    m_running = 0;
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b0;
    frame_cyc.delete();
    step(1'b1, SEG_B, 4'h6, 4'hF);
    #7;
    check_int("frame_after_reset", frame_cyc.size(), 1);
    run(FRAME, SEG_B, 4'h6, 4'hF);

    // randomized traffic
    r_seg = SEG_A; r_dp = 4'h0; r_br = 4'h9;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) r_seg = {$urandom(), $urandom()} >> 4;
      if ($urandom_range(0, 49) == 0) r_dp = 4'($urandom());
      if ($urandom_range(0, 29) == 0) r_br = 4'($urandom());
      step($urandom_range(0, 199) != 0, r_seg, r_dp, r_br);
    end

    @(posedge clk); @(posedge clk); #2;
    check_int("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
